// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared encodings for the multi-cycle RV64 control unit.
//   - opcode / funct3 / funct7 constants for the supported subset
//   - state_e : 4-bit FSM state encoding
//   - class_e : 3-bit instruction class encoding (R, I, LD, SD, BEQ, BAD)
package control_unit_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_DW  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_WB_ALU  = 4'd6,
        S_WB_MEM  = 4'd7,
        S_BRANCH  = 4'd8,
        S_ILLEGAL = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LD  = 3'd2,
        CLS_SD  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_BAD = 3'd5
    } class_e;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: control bus between control_unit and the RV64 datapath.
//   Datapath -> control: opcode, funct3, funct7 (from the IR), zero (ULA result == 0)
//   Control -> datapath: sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
//                        pc_next_sel, reset_pc, load_ir, retire, illegal
//   master: control unit side; slave: datapath side.
interface control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;

    logic       sub;
    logic       WE_RF;
    logic       WE_MEM;
    logic       RF_din_sel;
    logic       ULA_din2_sel;
    logic       load_pc;
    logic       pc_next_sel;
    logic       reset_pc;
    logic       load_ir;
    logic       retire;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7, zero,
        output sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
               pc_next_sel, reset_pc, load_ir, retire, illegal
    );

    modport slave (
        output opcode, funct3, funct7, zero,
        input  sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
               pc_next_sel, reset_pc, load_ir, retire, illegal
    );
endinterface

// File: rtl/control_unit_instr_class_decoder.sv
// instr_class_decoder: combinational map from (opcode, funct3, funct7) to an
// instruction class and the add/sub distinction for R-type.
//   opcode [6:0], funct3 [2:0], funct7 [6:0] : IR fields
//   iclass                                   : decoded class (CLS_BAD if unsupported)
//   is_sub                                   : 1 for R-type sub
module instr_class_decoder
    import control_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output class_e     iclass,
    output logic       is_sub
);

    always_comb begin
        iclass = CLS_BAD;
        is_sub = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD) begin
                    if (funct7 == F7_ADD) begin
                        iclass = CLS_R;
                    end else if (funct7 == F7_SUB) begin
                        iclass = CLS_R;
                        is_sub = 1'b1;
                    end
                end
            end
            OP_I:   if (funct3 == F3_ADD) iclass = CLS_I;
            OP_LD:  if (funct3 == F3_DW)  iclass = CLS_LD;
            OP_SD:  if (funct3 == F3_DW)  iclass = CLS_SD;
            OP_BEQ: if (funct3 == F3_BEQ) iclass = CLS_BEQ;
            default: iclass = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for the RV64 datapath
// (add, sub, addi, ld, sd, beq). Each instruction walks FETCH, DECODE, EXEC,
// then MEM/WB/BRANCH; unsupported encodings park in ILLEGAL until RST.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : control_unit_if.master (IR fields and zero in, control strobes out)
// Outputs are Moore (state + latched class), except that RST combinationally
// forces reset_pc=1 and every other output to 0.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    control_unit_if.master      bus
);

    state_e state_q, state_d;
    class_e class_q, class_d;
    logic   is_sub_q, is_sub_d;
    logic   zero_q, zero_d;

    class_e dec_class;
    logic   dec_is_sub;

    instr_class_decoder u_dec (
        .opcode (bus.opcode),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .iclass (dec_class),
        .is_sub (dec_is_sub)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_RESET;
            class_q  <= CLS_BAD;
            is_sub_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            is_sub_q <= is_sub_d;
            zero_q   <= zero_d;
        end
    end

    // Next state and side registers
    always_comb begin
        state_d  = state_q;
        class_d  = class_q;
        is_sub_d = is_sub_q;
        zero_d   = zero_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                class_d  = dec_class;
                is_sub_d = dec_is_sub;
                state_d  = (dec_class == CLS_BAD) ? S_ILLEGAL : S_EXEC;
            end
            S_EXEC: begin
                case (class_q)
                    CLS_R, CLS_I: state_d = S_WB_ALU;
                    CLS_LD:       state_d = S_MEM_RD;
                    CLS_SD:       state_d = S_MEM_WR;
                    CLS_BEQ: begin
                        state_d = S_BRANCH;
                        zero_d  = bus.zero;
                    end
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_RD: state_d = S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH: state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_RESET;
        endcase
    end

    logic o_sub, o_we_rf, o_we_mem, o_rf_sel, o_din2, o_load_pc;
    logic o_pc_sel, o_reset_pc, o_load_ir, o_retire, o_illegal;
    logic alu_uses_imm, alu_subtracts;

    assign alu_uses_imm  = (class_q == CLS_I) || (class_q == CLS_LD) || (class_q == CLS_SD);
    assign alu_subtracts = ((class_q == CLS_R) && is_sub_q) || (class_q == CLS_BEQ);

    // Output decode; RST override applied last
    always_comb begin
        o_sub      = 1'b0;
        o_we_rf    = 1'b0;
        o_we_mem   = 1'b0;
        o_rf_sel   = 1'b0;
        o_din2     = 1'b0;
        o_load_pc  = 1'b0;
        o_pc_sel   = 1'b0;
        o_reset_pc = 1'b0;
        o_load_ir  = 1'b0;
        o_retire   = 1'b0;
        o_illegal  = 1'b0;
        case (state_q)
            S_RESET: o_reset_pc = 1'b1;
            S_FETCH: o_load_ir  = 1'b1;
            S_EXEC: begin
                o_din2 = alu_uses_imm;
                o_sub  = alu_subtracts;
            end
            S_WB_ALU: begin
                o_we_rf   = 1'b1;
                o_rf_sel  = 1'b1;
                o_load_pc = 1'b1;
                o_retire  = 1'b1;
                o_din2    = alu_uses_imm;
                o_sub     = alu_subtracts;
            end
            S_MEM_RD: o_din2 = 1'b1;
            S_WB_MEM: begin
                o_we_rf   = 1'b1;
                o_din2    = 1'b1;
                o_load_pc = 1'b1;
                o_retire  = 1'b1;
            end
            S_MEM_WR: begin
                o_we_mem  = 1'b1;
                o_din2    = 1'b1;
                o_load_pc = 1'b1;
                o_retire  = 1'b1;
            end
            S_BRANCH: begin
                o_sub     = 1'b1;
                o_load_pc = 1'b1;
                o_retire  = 1'b1;
                o_pc_sel  = zero_q;
            end
            S_ILLEGAL: o_illegal = 1'b1;
            default: ;
        endcase
        if (RST) begin
            o_sub      = 1'b0;
            o_we_rf    = 1'b0;
            o_we_mem   = 1'b0;
            o_rf_sel   = 1'b0;
            o_din2     = 1'b0;
            o_load_pc  = 1'b0;
            o_pc_sel   = 1'b0;
            o_reset_pc = 1'b1;
            o_load_ir  = 1'b0;
            o_retire   = 1'b0;
            o_illegal  = 1'b0;
        end
    end

    assign bus.sub          = o_sub;
    assign bus.WE_RF        = o_we_rf;
    assign bus.WE_MEM       = o_we_mem;
    assign bus.RF_din_sel   = o_rf_sel;
    assign bus.ULA_din2_sel = o_din2;
    assign bus.load_pc      = o_load_pc;
    assign bus.pc_next_sel  = o_pc_sel;
    assign bus.reset_pc     = o_reset_pc;
    assign bus.load_ir      = o_load_ir;
    assign bus.retire       = o_retire;
    assign bus.illegal      = o_illegal;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. The stimulus process
// drives one input vector per cycle and pushes the expected output word for
// that cycle; the monitor pops and compares on the falling edge.
module tb_control_unit;

    logic CLK = 1'b0;
    logic RST;

    control_unit_if cu_if ();

    control_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (cu_if.master)
    );

    always #5 CLK = ~CLK;

    // Output word: {reset_pc, load_ir, sub, ULA_din2_sel, WE_RF, RF_din_sel,
    //               WE_MEM, load_pc, pc_next_sel, retire, illegal}
    localparam logic [10:0] RPC  = 11'h400;
    localparam logic [10:0] LIR  = 11'h200;
    localparam logic [10:0] SUB  = 11'h100;
    localparam logic [10:0] D2   = 11'h080;
    localparam logic [10:0] WRF  = 11'h040;
    localparam logic [10:0] RFS  = 11'h020;
    localparam logic [10:0] WMEM = 11'h010;
    localparam logic [10:0] LPC  = 11'h008;
    localparam logic [10:0] PCS  = 11'h004;
    localparam logic [10:0] RET  = 11'h002;
    localparam logic [10:0] ILL  = 11'h001;
    localparam logic [10:0] NONE = 11'h000;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_LD   = 32'h0000B103;
    localparam logic [31:0] I_SD   = 32'h0020B023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_LUI  = 32'h00000037;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic logic [10:0] act_word();
        return {cu_if.reset_pc, cu_if.load_ir, cu_if.sub, cu_if.ULA_din2_sel,
                cu_if.WE_RF, cu_if.RF_din_sel, cu_if.WE_MEM, cu_if.load_pc,
                cu_if.pc_next_sel, cu_if.retire, cu_if.illegal};
    endfunction

    // Monitor
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [10:0] a;
            e = sb.pop_front();
            a = act_word();
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %011b expected %011b (t=%0t)", e.name, a, e.exp, $time);
            end
        end
    end

    // One cycle: drive inputs just after the edge, record expected outputs.
    task automatic cyc(input string nm, input logic [10:0] exp, input logic rst,
                       input logic [31:0] ir, input logic z);
        exp_t e;
        @(posedge CLK);
        #1;
        RST          = rst;
        cu_if.opcode = ir[6:0];
        cu_if.funct3 = ir[14:12];
        cu_if.funct7 = ir[31:25];
        cu_if.zero   = z;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // FETCH, DECODE, EXEC, then one or two final cycles. After DECODE the IR
    // fields are replaced by junk and zero is flipped after EXEC, so the DUT
    // must rely on its latched class and zero_q.
    task automatic instr(input string nm, input logic [31:0] ir, input logic z,
                         input logic [10:0] e_ex, input logic [10:0] e_a,
                         input logic [10:0] e_b, input bit has_b);
        cyc({nm, "_fetch"},  LIR,  1'b0, ir, 1'b0);
        cyc({nm, "_decode"}, NONE, 1'b0, ir, 1'b0);
        cyc({nm, "_exec"},   e_ex, 1'b0, I_JUNK, z);
        cyc({nm, "_c4"},     e_a,  1'b0, I_JUNK, ~z);
        if (has_b) cyc({nm, "_c5"}, e_b, 1'b0, I_JUNK, ~z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST          = 1'b1;
        cu_if.opcode = '0;
        cu_if.funct3 = '0;
        cu_if.funct7 = '0;
        cu_if.zero   = 1'b0;

        for (int i = 0; i < 3; i++) cyc("reset_hold", RPC, 1'b1, '0, 1'b0);
        cyc("reset_state", RPC, 1'b0, '0, 1'b0);

        instr("add",  I_ADD,  1'b0, NONE, WRF | RFS | LPC | RET, NONE, 1'b0);
        instr("sub",  I_SUB,  1'b0, SUB, SUB | WRF | RFS | LPC | RET, NONE, 1'b0);
        instr("addi", I_ADDI, 1'b0, D2,  D2 | WRF | RFS | LPC | RET, NONE, 1'b0);
        instr("ld",   I_LD,   1'b0, D2,  D2, D2 | WRF | LPC | RET, 1'b1);
        instr("sd",   I_SD,   1'b0, D2,  WMEM | D2 | LPC | RET, NONE, 1'b0);
        instr("beq_t", I_BEQ, 1'b1, SUB, SUB | LPC | RET | PCS, NONE, 1'b0);
        instr("beq_f", I_BEQ, 1'b0, SUB, SUB | LPC | RET, NONE, 1'b0);

        // Illegal opcode: parked for 10 cycles, then RST recovers
        cyc("lui_fetch",  LIR,  1'b0, I_LUI, 1'b0);
        cyc("lui_decode", NONE, 1'b0, I_LUI, 1'b0);
        for (int i = 0; i < 10; i++) cyc("lui_illegal", ILL, 1'b0, I_ADD, 1'b1);
        cyc("lui_rst",   RPC, 1'b1, '0, 1'b0);
        cyc("lui_reset", RPC, 1'b0, '0, 1'b0);

        // add with bad funct7
        cyc("mul_fetch",  LIR,  1'b0, I_MUL, 1'b0);
        cyc("mul_decode", NONE, 1'b0, I_MUL, 1'b0);
        for (int i = 0; i < 10; i++) cyc("mul_illegal", ILL, 1'b0, I_ADD, 1'b0);
        cyc("mul_rst",   RPC, 1'b1, '0, 1'b0);
        cyc("mul_reset", RPC, 1'b0, '0, 1'b0);

        // RST landing on WB_ALU: no write, back to RESET
        cyc("rwb_fetch",  LIR,  1'b0, I_ADD, 1'b0);
        cyc("rwb_decode", NONE, 1'b0, I_ADD, 1'b0);
        cyc("rwb_exec",   NONE, 1'b0, I_ADD, 1'b0);
        cyc("rwb_rst",    RPC,  1'b1, I_ADD, 1'b0);
        cyc("rwb_reset",  RPC,  1'b0, '0, 1'b0);

        // RST landing on MEM_WR
        cyc("rsd_fetch",  LIR,  1'b0, I_SD, 1'b0);
        cyc("rsd_decode", NONE, 1'b0, I_SD, 1'b0);
        cyc("rsd_exec",   D2,   1'b0, I_SD, 1'b0);
        cyc("rsd_rst",    RPC,  1'b1, I_SD, 1'b0);
        cyc("rsd_reset",  RPC,  1'b0, '0, 1'b0);

        // Normal operation resumes
        instr("add2", I_ADD, 1'b0, NONE, WRF | RFS | LPC | RET, NONE, 1'b0);

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
